// File: rtl/int_sequencer_pkg.sv
// Shared encodings for the interrupt/reset sequencer: request sources,
// vector addresses and FSM states.
package int_pkg;

    typedef enum logic [1:0] {
        SRC_NONE = 2'b00,
        SRC_IRQ  = 2'b01,
        SRC_NMI  = 2'b10,
        SRC_RST  = 2'b11
    } src_t;

    localparam logic [15:0] VEC_NMI = 16'hFFFA;
    localparam logic [15:0] VEC_RST = 16'hFFFC;
    localparam logic [15:0] VEC_IRQ = 16'hFFFE;

    typedef enum logic [1:0] {
        HOLD,
        IDLE,
        REQ
    } state_t;

    function automatic logic [15:0] vec_for(input src_t src);
        logic [15:0] vec;
        vec = '0;
        case (src)
            SRC_IRQ:  vec = VEC_IRQ;
            SRC_NMI:  vec = VEC_NMI;
            SRC_RST:  vec = VEC_RST;
            default:  vec = '0;
        endcase
        return vec;
    endfunction

endpackage

// File: rtl/int_sequencer_sync_ff.sv
// Multi-flop synchroniser for an asynchronous active-low pin; resets to the
// inactive (high) level so no spurious edge is seen after reset.
module sync_ff #(
    parameter int unsigned DEPTH = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [DEPTH-1:0] stages;

    always_ff @(posedge clk) begin
        if (rst) begin
            stages <= '1;
        end else begin
            stages <= {stages[DEPTH-2:0], d};
        end
    end

    assign q = stages[DEPTH-1];

endmodule

// File: rtl/int_sequencer.sv
// Interrupt and reset sequencer: synchronises NMI/IRQ pins, runs the startup
// hold and presents one registered request (RESET > NMI > IRQ) to control.
module int_sequencer
    import int_pkg::*;
#(
    parameter int unsigned RST_CYCLES  = 6,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        nmi_n,
    input  logic        irq_n,
    input  logic [7:0]  P_in,
    input  logic        fetch_boundary,
    input  logic        int_ack,
    output logic        int_req,
    output logic [1:0]  int_src,
    output logic [15:0] vec_addr,
    output logic        cpu_hold
);

    localparam logic [3:0] CNT_INIT = 4'(RST_CYCLES - 1);

    logic       nmi_s;
    logic       irq_s;
    logic       nmi_prev;
    logic       nmi_pend;
    logic       nmi_fall;
    logic       irq_cond;
    logic [3:0] cnt;
    state_t     state;
    src_t       src_q;
    logic       unused_p;

    sync_ff #(.DEPTH(SYNC_STAGES)) u_sync_nmi (
        .clk (clk),
        .rst (rst),
        .d   (nmi_n),
        .q   (nmi_s)
    );

    sync_ff #(.DEPTH(SYNC_STAGES)) u_sync_irq (
        .clk (clk),
        .rst (rst),
        .d   (irq_n),
        .q   (irq_s)
    );

    assign nmi_fall = nmi_prev & ~nmi_s;
    assign irq_cond = ~irq_s & ~P_in[2];
    assign unused_p = ^{P_in[7:3], P_in[1:0]};

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= HOLD;
            cnt      <= CNT_INIT;
            nmi_prev <= 1'b1;
            nmi_pend <= 1'b0;
            int_req  <= 1'b0;
            src_q    <= SRC_NONE;
            vec_addr <= '0;
            cpu_hold <= 1'b1;
        end else begin
            nmi_prev <= nmi_s;

            // A fresh edge coinciding with the NMI ack must not be lost: set wins.
            if (state == REQ && int_ack && src_q == SRC_NMI) begin
                nmi_pend <= 1'b0;
            end
            if (nmi_fall) begin
                nmi_pend <= 1'b1;
            end

            case (state)
                HOLD: begin
                    if (cnt == 4'd0) begin
                        state    <= REQ;
                        cpu_hold <= 1'b0;
                        int_req  <= 1'b1;
                        src_q    <= SRC_RST;
                        vec_addr <= vec_for(SRC_RST);
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                IDLE: begin
                    if (fetch_boundary && (nmi_pend || irq_cond)) begin
                        state   <= REQ;
                        int_req <= 1'b1;
                        if (nmi_pend) begin
                            src_q    <= SRC_NMI;
                            vec_addr <= vec_for(SRC_NMI);
                        end else begin
                            src_q    <= SRC_IRQ;
                            vec_addr <= vec_for(SRC_IRQ);
                        end
                    end
                end
                REQ: begin
                    if (int_ack) begin
                        state    <= IDLE;
                        int_req  <= 1'b0;
                        src_q    <= SRC_NONE;
                        vec_addr <= '0;
                    end
                end
                default: begin
                    state <= HOLD;
                    cnt   <= CNT_INIT;
                end
            endcase
        end
    end

    assign int_src = src_q;

endmodule

// File: tb/tb_int_sequencer.sv
// Directed bench for int_sequencer with hand-computed expectations.
module tb_int_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        nmi_n;
    logic        irq_n;
    logic [7:0]  P_in;
    logic        fetch_boundary;
    logic        int_ack;
    logic        int_req;
    logic [1:0]  int_src;
    logic [15:0] vec_addr;
    logic        cpu_hold;

    int checks = 0;
    int errors = 0;

    int_sequencer #(.RST_CYCLES(6), .SYNC_STAGES(2)) dut (
        .clk            (clk),
        .rst            (rst),
        .nmi_n          (nmi_n),
        .irq_n          (irq_n),
        .P_in           (P_in),
        .fetch_boundary (fetch_boundary),
        .int_ack        (int_ack),
        .int_req        (int_req),
        .int_src        (int_src),
        .vec_addr       (vec_addr),
        .cpu_hold       (cpu_hold)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_req(input string tag, input logic req, input logic [1:0] src,
                             input logic [15:0] vec);
        check({tag, "_req"}, {15'd0, int_req}, {15'd0, req});
        check({tag, "_src"}, {14'd0, int_src}, {14'd0, src});
        check({tag, "_vec"}, vec_addr, vec);
    endtask

    task automatic do_ack(input string tag);
        int_ack = 1'b1;
        tick();
        int_ack = 1'b0;
        check_req(tag, 1'b0, 2'b00, 16'h0000);
    endtask

    task automatic boundary();
        fetch_boundary = 1'b1;
        tick();
        fetch_boundary = 1'b0;
    endtask

    // Releases rst and expects exactly 6 held cycles before the RESET request.
    task automatic startup(input string tag);
        rst = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            tick();
            check({tag, "_hold"}, {15'd0, cpu_hold}, 16'd1);
            check({tag, "_noreq"}, {15'd0, int_req}, 16'd0);
        end
        tick();
        check({tag, "_hold_fall"}, {15'd0, cpu_hold}, 16'd0);
        check_req({tag, "_rst"}, 1'b1, 2'b11, 16'hFFFC);
    endtask

    initial begin
        rst = 1'b1;
        nmi_n = 1'b1;
        irq_n = 1'b1;
        P_in = 8'h04;
        fetch_boundary = 1'b0;
        int_ack = 1'b0;

        // Reset state and startup
        tick();
        check("rst_hold", {15'd0, cpu_hold}, 16'd1);
        check_req("rst_out", 1'b0, 2'b00, 16'h0000);
        tick();
        tick();
        startup("start1");
        boundary();
        check_req("rst_ignores_fb", 1'b1, 2'b11, 16'hFFFC);
        do_ack("rst_ack");
        tick();

        // NMI one-cycle pulse, boundary 5 cycles after the fall
        nmi_n = 1'b0;
        tick();
        nmi_n = 1'b1;
        tick();
        check("nmi_pend_early", {15'd0, dut.nmi_pend}, 16'd0);
        tick();
        check("nmi_pend_set", {15'd0, dut.nmi_pend}, 16'd1);
        tick();
        tick();
        boundary();
        check_req("nmi_pulse", 1'b1, 2'b10, 16'hFFFA);
        do_ack("nmi_pulse_ack");
        check("nmi_pend_clr", {15'd0, dut.nmi_pend}, 16'd0);

        // NMI held low: one request only
        nmi_n = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        boundary();
        check_req("nmi_held", 1'b1, 2'b10, 16'hFFFA);
        do_ack("nmi_held_ack");
        for (int i = 0; i < 3; i++) begin
            boundary();
            check("nmi_held_norepeat", {15'd0, int_req}, 16'd0);
            tick();
        end
        nmi_n = 1'b1;
        for (int i = 0; i < 4; i++) tick();

        // IRQ masking
        irq_n = 1'b0;
        P_in = 8'h04;
        for (int i = 0; i < 3; i++) tick();
        for (int i = 0; i < 3; i++) begin
            boundary();
            check("irq_masked", {15'd0, int_req}, 16'd0);
            tick();
        end
        P_in = 8'h00;
        boundary();
        check_req("irq_unmask", 1'b1, 2'b01, 16'hFFFE);
        do_ack("irq_ack");
        irq_n = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        boundary();
        check("irq_released", {15'd0, int_req}, 16'd0);
        tick();

        // Priority: NMI and IRQ at the same boundary
        irq_n = 1'b0;
        nmi_n = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        boundary();
        check_req("prio_nmi", 1'b1, 2'b10, 16'hFFFA);
        do_ack("prio_nmi_ack");
        nmi_n = 1'b1;
        boundary();
        check_req("prio_irq", 1'b1, 2'b01, 16'hFFFE);

        // NMI edge while IRQ request is pending: no upgrade
        tick();
        tick();
        nmi_n = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        check_req("coll_irq_kept", 1'b1, 2'b01, 16'hFFFE);
        check("coll_nmi_pend", {15'd0, dut.nmi_pend}, 16'd1);
        boundary();
        check_req("coll_irq_fb_ignored", 1'b1, 2'b01, 16'hFFFE);
        do_ack("coll_irq_ack");
        boundary();
        check_req("coll_nmi_follows", 1'b1, 2'b10, 16'hFFFA);

        // New NMI edge detected on the same edge as the NMI ack
        irq_n = 1'b1;
        nmi_n = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        nmi_n = 1'b0;
        tick();
        tick();
        check("ackcoll_pend_before", {15'd0, dut.nmi_pend}, 16'd1);
        do_ack("ackcoll_ack");
        check("ackcoll_pend_kept", {15'd0, dut.nmi_pend}, 16'd1);
        boundary();
        check_req("ackcoll_second_nmi", 1'b1, 2'b10, 16'hFFFA);

        // Reset mid-REQ
        rst = 1'b1;
        tick();
        check_req("midreq_rst", 1'b0, 2'b00, 16'h0000);
        check("midreq_hold", {15'd0, cpu_hold}, 16'd1);
        check("midreq_pend", {15'd0, dut.nmi_pend}, 16'd0);
        nmi_n = 1'b1;
        tick();
        tick();
        startup("start2");
        do_ack("start2_ack");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
